// File: rtl/sobol_gen_par_pkg.sv
// Shared defaults, FSM state type and the least-significant-zero helper
// for the parallel Sobol generator.
package sobol_gen_par_pkg;

  localparam int SOBOL_W     = 16;
  localparam int SOBOL_DIMS  = 2;
  localparam int SOBOL_LANES = 4;
  localparam int SOBOL_CNT_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Bit position of the lowest zero; 64 when the input is all ones.
  function automatic int lsz(input logic [63:0] idx);
    int pos;
    pos = 64;
    for (int i = 63; i >= 0; i--) begin
      if (!idx[i]) pos = i;
    end
    return pos;
  endfunction

endpackage

// File: rtl/sobol_gen_par_if.sv
// Output beat stream of the Sobol generator: valid/ready with data and last.
// The master holds data/last stable while valid is high and ready is low.
interface sobol_gen_par_if #(
  parameter int W     = 16,
  parameter int DIMS  = 2,
  parameter int LANES = 4
);
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*DIMS*W-1:0]   out_data;
  logic                      out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/sobol_gen_par_dv_store.sv
// Direction-vector register file: DIMS*W entries of W bits, van der Corput at reset.
// Writes land one cycle after the strobe; reads are a flat combinational bus.
module sobol_dv_store #(
  parameter int W    = 16,
  parameter int DIMS = 2,
  localparam int N   = DIMS * W,
  localparam int AW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic [W-1:0]        wdata,
  output logic [N-1:0][W-1:0] v_all
);

  logic [W-1:0] v_q [N];
  logic [W-1:0] v_d [N];

  always_comb begin
    for (int i = 0; i < N; i++) v_d[i] = v_q[i];
    if (we && (int'(addr) < N)) v_d[addr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) v_q[i] <= W'(1) << (W - 1 - (i % W));
    end else begin
      for (int i = 0; i < N; i++) v_q[i] <= v_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) v_all[i] = v_q[i];
  end

endmodule

// File: rtl/sobol_gen_par.sv
// Multi-lane Sobol point generator: LANES Gray-order points x DIMS dims per beat.
// First beat one cycle after start; beats held under backpressure, full rate when ready.
module sobol_gen_par
  import sobol_gen_par_pkg::*;
#(
  parameter int W     = SOBOL_W,
  parameter int DIMS  = SOBOL_DIMS,
  parameter int LANES = SOBOL_LANES,
  parameter int CNT_W = SOBOL_CNT_W,
  localparam int AW   = (DIMS * W > 1) ? $clog2(DIMS * W) : 1,
  localparam int IW   = (W > 1) ? $clog2(W) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [CNT_W-1:0]      num_beats,
  input  logic                  cfg_we,
  input  logic [AW-1:0]         cfg_addr,
  input  logic [W-1:0]          cfg_data,
  sobol_gen_par_if.master       out_if,
  output logic                  busy,
  output logic                  done
);

  state_e                             state_q, state_d;
  logic [CNT_W-1:0]                   idx_q, idx_d;
  logic [CNT_W-1:0]                   beat_q, beat_d;
  logic [CNT_W-1:0]                   nb_q, nb_d;
  logic [DIMS-1:0][W-1:0]             x_q, x_d;
  logic                               valid_q, valid_d;
  logic [LANES-1:0][DIMS-1:0][W-1:0]  data_q, data_d;
  logic                               last_q, last_d;
  logic                               done_q, done_d;

  logic [DIMS-1:0][W-1:0][W-1:0]      v_all;
  logic [LANES-1:0][DIMS-1:0][W-1:0]  lane;
  logic [CNT_W-1:0]                   base_idx;
  logic [CNT_W-1:0]                   beat_no;
  logic [CNT_W-1:0]                   nb_eff;
  logic [W-1:0]                       prev;
  logic [W-1:0]                       term;
  logic [IW-1:0]                      c_idx;
  int                                 c;
  logic                               fresh;
  logic                               adv;

  sobol_dv_store #(.W(W), .DIMS(DIMS)) u_dv_store (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_we && (state_q == IDLE)),
    .addr  (cfg_addr),
    .wdata (cfg_data),
    .v_all (v_all)
  );

  assign fresh = (state_q == IDLE) && start && !abort;
  assign adv   = (state_q == RUN) && valid_q && out_if.out_ready && !abort;

  // A new run starts its chain from x_0 = 0 at index 0, not from stale state.
  always_comb begin
    base_idx = fresh ? '0 : idx_q;
    prev     = '0;
    term     = '0;
    c        = 0;
    c_idx    = '0;
    lane     = '0;
    for (int d = 0; d < DIMS; d++) begin
      prev = fresh ? '0 : x_q[d];
      for (int j = 0; j < LANES; j++) begin
        c     = lsz(64'(base_idx + CNT_W'(j)));
        c_idx = c[IW-1:0];
        term  = (c < W) ? v_all[d][c_idx] : '0;
        prev  = prev ^ term;
        lane[j][d] = prev;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    nb_d    = nb_q;
    x_d     = x_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    done_d  = 1'b0;
    beat_no = fresh ? '0 : beat_q + CNT_W'(1);
    nb_eff  = fresh ? num_beats : nb_q;
    if (abort) begin
      state_d = IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
      idx_d   = '0;
      beat_d  = '0;
      x_d     = '0;
    end else if (fresh || (adv && !last_q)) begin
      state_d = RUN;
      valid_d = 1'b1;
      data_d  = lane;
      x_d     = lane[LANES-1];
      idx_d   = base_idx + CNT_W'(LANES);
      beat_d  = beat_no;
      nb_d    = nb_eff;
      last_d  = (nb_eff != '0) && (beat_no == nb_eff - CNT_W'(1));
    end else if (adv) begin
      state_d = IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      beat_q  <= '0;
      nb_q    <= '0;
      x_q     <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      nb_q    <= nb_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_last  = last_q;
  assign busy             = (state_q == RUN);
  assign done             = done_q;

endmodule
